bch_blank_detect: RTL and testbench

Read-side counterpart of the encoder's erased-flash ECC mask. It sits between the flash read stream and the syndrome calculator. It XORs the ECC portion of each incoming codeword with the same erased-ECC pattern the encode path applies, so that the syndrome stage sees true ECC bits. In parallel it counts zero bits over the whole codeword and flags the page as erased (blank) when the count is at or below a threshold, so the decoder can skip correction of blank pages.

---
 rtl/bch_blank_detect.sv | 159 +++++++++++++++
 tb/tb_bch_blank_detect.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_blank_detect.sv
// Read-side erased-page detector: strips the erased-ECC mask from the ECC words of each
// incoming codeword and counts zero bits to flag blank (erased) pages.
module bch_blank_detect #(
    parameter int              DATA_BITS = 21,
    parameter int              EB        = 10,
    parameter logic [EB-1:0]   GEN_POLY  = 10'h369,
    parameter int              BITS      = 1,
    parameter int              THRESHOLD = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            ce,
    input  logic [BITS-1:0]                 data_in,
    output logic [BITS-1:0]                 data_out,
    output logic                            valid_out,
    output logic                            first,
    output logic                            last,
    output logic                            done,
    output logic                            erased,
    output logic [$clog2(THRESHOLD+2)-1:0]  zero_count
);

    localparam int DATA_WORDS = (DATA_BITS + BITS - 1) / BITS;
    localparam int ECC_WORDS  = (EB + BITS - 1) / BITS;
    localparam int N_WORDS    = DATA_WORDS + ECC_WORDS;
    localparam int DATA_PAD   = DATA_WORDS * BITS - DATA_BITS;
    localparam int ECC_PAD    = ECC_WORDS * BITS - EB;
    localparam int MASK_W     = ECC_WORDS * BITS;
    localparam int CW         = $clog2(N_WORDS + 1);
    localparam int ZCW        = $clog2(THRESHOLD + 2);
    localparam int ZW         = $clog2(BITS + 1);
    localparam int SUMW       = ((ZCW > ZW) ? ZCW : ZW) + 1;
    localparam int SAT        = THRESHOLD + 1;

    // Same LFSR run the encoder uses: all-ones message, result inverted.
    function automatic logic [EB-1:0] erased_ecc_f();
        logic [EB-1:0] r;
        logic          fb;
        r = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            fb = 1'b1 ^ r[EB-1];
            r  = {r[EB-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
        return ~r;
    endfunction

    function automatic logic [ZW-1:0] popcount(input logic [BITS-1:0] v);
        logic [ZW-1:0] n;
        n = '0;
        for (int i = 0; i < BITS; i++) n = n + ZW'(v[i]);
        return n;
    endfunction

    localparam logic [MASK_W-1:0] MASK        = MASK_W'(erased_ecc_f()) << ECC_PAD;
    localparam logic [BITS-1:0]   ALL_ONES    = '1;
    localparam logic [BITS-1:0]   FIRST_VALID = ALL_ONES >> DATA_PAD;
    localparam logic [BITS-1:0]   LAST_VALID  = ALL_ONES << ECC_PAD;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ECC} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ZCW-1:0]     zc_q, zc_d;
    logic               erased_q, erased_d;
    logic [BITS-1:0]    data_out_q, data_out_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic               accept;
    logic [CW-1:0]      widx;
    logic               in_ecc;
    logic               is_last;
    int                 ecc_k;
    logic [BITS-1:0]    mask_word;
    logic [BITS-1:0]    vmask;
    logic [SUMW-1:0]    sum;

    // A start always restarts at word 0, even mid-codeword (abort).
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        accept     = start || (ce && (state_q != S_IDLE));
        widx       = start ? '0 : cnt_q;
        in_ecc     = (widx >= CW'(DATA_WORDS));
        is_last    = (widx == CW'(N_WORDS - 1));
        ecc_k      = in_ecc ? (int'(widx) - DATA_WORDS) : 0;
        mask_word  = in_ecc ? BITS'(MASK >> ((ECC_WORDS - 1 - ecc_k) * BITS)) : '0;

        vmask = ALL_ONES;
        if (!in_ecc && (widx == '0)) vmask = FIRST_VALID;
        if (is_last)                 vmask = vmask & LAST_VALID;

        sum = (start ? '0 : SUMW'(zc_q)) + SUMW'(popcount(~data_in & vmask));

        state_d    = state_q;
        cnt_d      = cnt_q;
        zc_d       = zc_q;
        erased_d   = erased_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        first_d    = first_q;
        last_d     = last_q;
        done_d     = 1'b0;

        if (accept) begin
            data_out_d = data_in ^ mask_word;
            valid_d    = 1'b1;
            first_d    = (widx == '0);
            last_d     = is_last;
            zc_d       = (sum > SUMW'(SAT)) ? ZCW'(SAT) : ZCW'(sum);
            if (start) erased_d = 1'b0;
            if (is_last) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                done_d   = 1'b1;
                erased_d = (sum <= SUMW'(THRESHOLD));
            end else begin
                cnt_d   = widx + CW'(1);
                state_d = ((widx + CW'(1)) < CW'(DATA_WORDS)) ? S_DATA : S_ECC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            zc_q       <= '0;
            erased_q   <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zc_q       <= zc_d;
            erased_q   <= erased_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_q;
    assign first      = first_q;
    assign last       = last_q;
    assign done       = done_q;
    assign erased     = erased_q;
    assign zero_count = zc_q;

endmodule

// File: tb/tb_bch_blank_detect.sv
// Self-checking bench for bch_blank_detect: random and directed codewords compared against a
// polynomial-division reference model of the erased-ECC mask and zero counting.
module tb_bch_blank_detect;

    localparam int              DATA_BITS  = 21;
    localparam int              EB         = 10;
    localparam logic [EB-1:0]   GEN_POLY   = 10'h369;
    localparam int              BITS       = 4;
    localparam int              THRESHOLD  = 4;
    localparam int              DATA_WORDS = (DATA_BITS + BITS - 1) / BITS;
    localparam int              ECC_WORDS  = (EB + BITS - 1) / BITS;
    localparam int              N          = DATA_WORDS + ECC_WORDS;
    localparam int              TOT        = N * BITS;
    localparam int              ECC_PAD    = ECC_WORDS * BITS - EB;
    localparam int              BODY       = DATA_BITS + EB;
    localparam int              ZCW        = $clog2(THRESHOLD + 2);

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            ce;
    logic [BITS-1:0] data_in;
    logic [BITS-1:0] data_out;
    logic            valid_out;
    logic            first;
    logic            last;
    logic            done;
    logic            erased;
    logic [ZCW-1:0]  zero_count;

    bch_blank_detect #(
        .DATA_BITS (DATA_BITS),
        .EB        (EB),
        .GEN_POLY  (GEN_POLY),
        .BITS      (BITS),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ce         (ce),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .first      (first),
        .last       (last),
        .done       (done),
        .erased     (erased),
        .zero_count (zero_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [EB-1:0]   mask_ecc;
    logic [BITS-1:0] exp_words[$];
    logic [BITS-1:0] got_words[$];
    logic [BITS-1:0] cur_words[$];
    int              exp_er[$];
    int              exp_zc[$];
    int              got_er[$];
    int              got_zc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Systematic BCH parity: remainder of msg(x)*x^EB divided by g(x), msg MSB streamed first.
    function automatic logic [EB-1:0] ecc_of(input logic [DATA_BITS-1:0] msg);
        logic [BODY-1:0] dv;
        logic [BODY-1:0] g;
        dv = {msg, {EB{1'b0}}};
        g  = BODY'({1'b1, GEN_POLY});
        for (int i = BODY - 1; i >= EB; i--)
            if (dv[i]) dv = dv ^ (g << (i - EB));
        return dv[EB-1:0];
    endfunction

    // Codeword bit string, first streamed bit at the MSB; pad bits all set to pad.
    function automatic logic [TOT-1:0] make_cw(input logic [BODY-1:0] b, input bit pad);
        logic [TOT-1:0] c;
        c = pad ? '1 : '0;
        c[ECC_PAD +: BODY] = b;
        return c;
    endfunction

    task automatic expect_cw(input logic [BODY-1:0] b, input bit pad);
        logic [TOT-1:0] outcw;
        int             zeros;
        outcw = make_cw(b, pad) ^ (TOT'(mask_ecc) << ECC_PAD);
        zeros = $countones(~b);
        for (int w = 0; w < N; w++) exp_words.push_back(outcw[TOT-1-w*BITS -: BITS]);
        exp_er.push_back((zeros <= THRESHOLD) ? 1 : 0);
        exp_zc.push_back((zeros > THRESHOLD + 1) ? THRESHOLD + 1 : zeros);
    endtask

    task automatic drive(input logic [TOT-1:0] c, input int gap_pct, input int n_words);
        for (int w = 0; w < n_words; w++) begin
            if (w > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    start   = 1'b0;
                    ce      = 1'b0;
                    data_in = BITS'($urandom);
                    @(posedge clk); #1;
                end
            end
            start   = (w == 0);
            ce      = (w == 0) ? 1'($urandom_range(1)) : 1'b1;
            data_in = c[TOT-1-w*BITS -: BITS];
            @(posedge clk); #1;
        end
        start = 1'b0;
        ce    = 1'b0;
    endtask

    task automatic send(input logic [BODY-1:0] b, input bit pad, input int gap_pct);
        expect_cw(b, pad);
        drive(make_cw(b, pad), gap_pct, N);
    endtask

    task automatic wait_done(input string tag, input int k);
        int cyc = 0;
        while (got_er.size() < k && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_count"}, got_er.size(), k);
    endtask

    task automatic compare_all(input string tag);
        int i;
        check({tag, "_n_words"}, got_words.size(), exp_words.size());
        i = 0;
        while (exp_er.size() > 0 && got_er.size() > 0) begin
            check($sformatf("%s_erased%0d", tag, i), got_er.pop_front(), exp_er.pop_front());
            check($sformatf("%s_zc%0d", tag, i), got_zc.pop_front(), exp_zc.pop_front());
            i++;
        end
        i = 0;
        while (exp_words.size() > 0 && got_words.size() > 0) begin
            check($sformatf("%s_word%0d", tag, i), got_words.pop_front(), exp_words.pop_front());
            i++;
        end
        exp_words.delete(); got_words.delete();
        exp_er.delete(); exp_zc.delete(); got_er.delete(); got_zc.delete();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (valid_out) begin
                if (first) cur_words.delete();
                cur_words.push_back(data_out);
            end
            if (done) begin
                check("done_with_valid_last", {30'd0, valid_out, last}, 32'd3);
                check("done_word_count", cur_words.size(), N);
                foreach (cur_words[i]) got_words.push_back(cur_words[i]);
                got_er.push_back(int'(erased));
                got_zc.push_back(int'(zero_count));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BODY-1:0]      b;
        logic [DATA_BITS-1:0] msg;

        mask_ecc = ~ecc_of('1);
        reset_n  = 1'b0;
        start    = 1'b0;
        ce       = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs",
              {data_out, valid_out, first, last, done, erased, zero_count}, 32'd0);

        // All-ones blank page, then the held result a few idle cycles later.
        send('1, 1'b1, 0);
        wait_done("ones", 1);
        compare_all("ones");
        repeat (3) @(posedge clk);
        #1;
        check("erased_hold", erased, 1);
        check("zc_hold", zero_count, 0);

        // Exactly THRESHOLD zeros across data and ECC, then one more.
        b = '1;
        b[BODY-1] = 1'b0; b[EB+3] = 1'b0; b[EB-1] = 1'b0; b[0] = 1'b0;
        send(b, 1'b1, 0);
        b[EB+10] = 1'b0;
        send(b, 1'b1, 0);
        wait_done("thresh", 2);
        compare_all("thresh");

        // Genuine encoded codewords with the erased mask applied by the writer.
        for (int i = 0; i < 3; i++) begin
            msg = DATA_BITS'($urandom);
            send({msg, ecc_of(msg) ^ mask_ecc}, 1'($urandom_range(1)), 0);
        end
        wait_done("enc", 3);
        compare_all("enc");

        // ce gaps and zero pad bits on blank pages.
        send('1, 1'b1, 50);
        send('1, 1'b0, 0);
        send('1, 1'b0, 50);
        wait_done("gaps_pad", 3);
        compare_all("gaps_pad");

        // Near-threshold blank pages and fully random pages, back to back, some gapped.
        for (int i = 0; i < 8; i++) begin
            b = '1;
            for (int j = 0; j < $urandom_range(7); j++) b[$urandom_range(BODY-1)] = 1'b0;
            if (i % 4 == 3) b = BODY'({$urandom, $urandom});
            send(b, 1'($urandom_range(1)), (i % 2 == 1) ? 40 : 0);
        end
        wait_done("random", 8);
        compare_all("random");

        // Abort at word N/2, restart immediately with a full blank page.
        drive(make_cw(BODY'({$urandom, $urandom}), 1'b1), 0, N / 2);
        send('1, 1'b1, 0);
        wait_done("abort", 1);
        repeat (5) @(posedge clk);
        #1;
        check("abort_single_done", got_er.size(), 1);
        compare_all("abort");

        // Reset in the middle of the ECC words, then a normal codeword.
        drive(make_cw('1, 1'b1), 0, DATA_WORDS + 1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              {data_out, valid_out, first, last, done, erased, zero_count}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("after_reset_no_done", got_er.size(), 0);
        b = '1;
        b[5] = 1'b0;
        send(b, 1'b1, 20);
        wait_done("post_reset", 1);
        compare_all("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
